// File: rtl/shift_add_mult8.sv
// ---------------------------------------------------------------------------
// shift_add_mult8 -- sequential 8x8 unsigned multiplier.
//
// Forms a*b with one shift-and-add iteration per clock. The only arithmetic
// element is the 8-bit ripple-carry adder Adder8. Its inputs come from the
// accumulator and multiplicand registers, and its sum/carry-out are shifted
// back into {acc, q} on every RUN edge.
//
// Ports (shift_add_mult8):
//   clk      in   1  clock, rising-edge active
//   rst      in   1  synchronous active-high reset
//   start    in   1  multiply request, accepted in IDLE or DONE only
//   a        in   8  multiplicand (sampled on the accepting edge)
//   b        in   8  multiplier   (sampled on the accepting edge)
//   busy     out  1  high while iterating (state RUN)
//   done     out  1  one-cycle pulse while state is DONE
//   product  out 16  registered result, held until the next final iteration
//
// Ports (Adder8):
//   A, B     in   8  operands
//   Cin      in   1  carry in
//   S        out  8  sum
//   Cout     out  1  carry out
// ---------------------------------------------------------------------------

module Adder8 (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);

  logic [8:0] carry;

  assign carry[0] = Cin;

  // One full-adder cell per bit, rippling the carry upward.
  for (genvar gi = 0; gi < 8; gi++) begin : g_fa
    assign S[gi]       = A[gi] ^ B[gi] ^ carry[gi];
    assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
  end

  assign Cout = carry[8];

endmodule

module shift_add_mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  logic [7:0]  add_s;
  logic        add_cout;
  logic [8:0]  partial;   // {c, s}: acc+M when q[0] is set, else acc
  logic [15:0] shifted;   // {acc, q} after this iteration's right shift

  Adder8 u_adder (
    .A    (acc_q),
    .B    (m_q),
    .Cin  (1'b0),
    .S    (add_s),
    .Cout (add_cout)
  );

  always_comb begin
    partial = q_q[0] ? {add_cout, add_s} : {1'b0, acc_q};
    // Shift right by one across the 17-bit {c, s, q}; q[0] is dropped.
    shifted = {partial, q_q[7:1]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a;
          acc_d   = 8'd0;
          q_d     = b;
          cnt_d   = 4'd0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        acc_d = shifted[15:8];
        q_d   = shifted[7:0];
        cnt_d = cnt_q + 4'd1;
        // Eighth iteration: capture the finished product straight from the
        // shifter so it is valid in the same cycle that done rises.
        if (cnt_q == 4'd7) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= 8'd0;
      acc_q     <= 8'd0;
      q_q       <= 8'd0;
      cnt_q     <= 4'd0;
      product_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Status outputs decode registered state only.
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult8.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mult8 -- directed self-checking bench for shift_add_mult8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------

module tb_shift_add_mult8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  shift_add_mult8 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a start for one edge (E0), then check busy across E0..E7.
  task automatic accept_and_run(input logic [7:0] av, input logic [7:0] bv, input string tag);
    a = av; b = bv; start = 1'b1;
    step();                       // E0
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " done"}, done, 0);
      step();                     // E1..E7
    end
    check({tag, " busy"}, busy, 1);
    step();                       // E8
  endtask

  task automatic check_done(input logic [15:0] exp, input string tag);
    check({tag, " done_hi"}, done, 1);
    check({tag, " busy_lo"}, busy, 0);
    check({tag, " product"}, product, {16'd0, exp});
    $display("mul %s: product=%0d expected=%0d", tag, product, exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    step(); step();
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      check("idle product", product, 0);
      check("idle busy", busy, 0);
      check("idle done", done, 0);
      step();
    end

    // 13 x 11, result must hold afterwards.
    accept_and_run(8'd13, 8'd11, "13x11");
    check_done(16'd143, "13x11");
    for (int i = 0; i < 5; i++) begin
      step();
      check("13x11 hold product", product, 143);
      check("13x11 hold done", done, 0);
      check("13x11 hold busy", busy, 0);
    end

    // Corners.
    accept_and_run(8'd0, 8'd200, "0x200");
    check_done(16'd0, "0x200");
    step(); check("0x200 done_fall", done, 0);
    accept_and_run(8'd255, 8'd1, "255x1");
    check_done(16'd255, "255x1");
    step(); check("255x1 done_fall", done, 0);
    accept_and_run(8'd255, 8'd255, "255x255");
    check_done(16'd65025, "255x255");
    step(); check("255x255 done_fall", done, 0);
    accept_and_run(8'd250, 8'd9, "250x9");
    check_done(16'd2250, "250x9");
    step();

    // start during RUN must be ignored.
    a = 8'd100; b = 8'd3; start = 1'b1;
    step();                       // E0
    start = 1'b0;
    step(); step();               // E1, E2
    a = 8'd7; b = 8'd7; start = 1'b1;
    step();                       // E3
    start = 1'b0;
    check("ignore busy_E3", busy, 1);
    for (int i = 0; i < 5; i++) begin
      check("ignore done_early", done, 0);
      step();                     // E4..E8
    end
    check_done(16'd300, "100x3");
    for (int i = 0; i < 3; i++) begin
      step();
      check("ignore no_second_done", done, 0);
      check("ignore no_rerun", busy, 0);
      check("ignore product_hold", product, 300);
    end

    // Back-to-back: 6x7 then 12x12 accepted in the DONE cycle.
    accept_and_run(8'd6, 8'd7, "6x7");
    check_done(16'd42, "6x7");
    a = 8'd12; b = 8'd12; start = 1'b1;
    step();                       // E9 / new E0
    start = 1'b0;
    check("b2b busy_rise", busy, 1);
    check("b2b done_fall", done, 0);
    check("b2b product_hold", product, 42);
    for (int i = 0; i < 7; i++) begin
      step();
      check("b2b busy", busy, 1);
    end
    step();
    check_done(16'd144, "12x12");
    step();

    // Reset in the middle of an operation.
    a = 8'd200; b = 8'd200; start = 1'b1;
    step();                       // E0
    start = 1'b0;
    step(); step(); step();       // E1..E3
    rst = 1'b1;
    step();                       // E4
    rst = 1'b0;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst product", product, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("rst no_done", done, 0);
      check("rst no_busy", busy, 0);
      check("rst product_zero", product, 0);
    end
    accept_and_run(8'd5, 8'd5, "5x5");
    check_done(16'd25, "5x5");
    step();
    check("5x5 done_fall", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
